// File: rtl/or_pair_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module : or_pkg
//  Brief  : Shared types and helpers for the OR-gate pair sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
package or_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    function automatic int num_pairs(input int n);
        return n * (n + 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/or_pair_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : or_pair_sequencer
//  Brief  : Latches an N-bit vector and streams every (i, j>=i) operand pair
//           over valid/ready. Define OR_PAIR_REF_EN to register out_y = a|b.
//  Rev    : 1.0  initial release
// ============================================================================
module or_pair_sequencer
    import or_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int NP = num_pairs(N),
    localparam int CW = $clog2(NP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  vec_in,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_a,
    output logic          out_b,
    output logic [IW-1:0] out_i,
    output logic [IW-1:0] out_j,
    output logic          out_y,
    output logic [CW-1:0] pair_cnt,
    output logic          done
);

    localparam logic [IW-1:0] c_last_idx = IW'(N - 1);

    seq_state_e    r_state, w_state_nxt;
    logic [N-1:0]  r_vec,   w_vec_nxt;
    logic [IW-1:0] r_i,     w_i_nxt;
    logic [IW-1:0] r_j,     w_j_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          r_a,     w_a_nxt;
    logic          r_b,     w_b_nxt;
    logic [IW-1:0] w_i_inc, w_j_inc;

    assign w_i_inc = r_i + IW'(1);
    assign w_j_inc = r_j + IW'(1);

    // Payload for the next pair is computed here so it lands in the output
    // registers on the same edge that retires the current pair.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_vec_nxt   = vec_in;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_a_nxt     = vec_in[0];
                    w_b_nxt     = vec_in[0];
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_j < c_last_idx) begin
                        w_j_nxt = w_j_inc;
                        w_b_nxt = r_vec[w_j_inc];
                    end else if (r_i < c_last_idx) begin
                        w_i_nxt = w_i_inc;
                        w_j_nxt = w_i_inc;
                        w_a_nxt = r_vec[w_i_inc];
                        w_b_nxt = r_vec[w_i_inc];
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
        end
    end

`ifdef OR_PAIR_REF_EN
    logic r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_a_nxt | w_b_nxt;
        end
    end

    assign out_y = r_y;
`else
    assign out_y = 1'b0;
`endif

    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_i     = r_i;
    assign out_j     = r_j;
    assign pair_cnt  = r_cnt;

endmodule
`default_nettype wire
